uart_tx: RTL and testbench

//   UART transmitter: serialises bytes as 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity).

---
 rtl/uart_tx.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with a small write FIFO in front of the line FSM
module uart_tx #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FIFO_ADDR_W  = 2
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Tx_DV,
  input  logic [7:0]           i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic [FIFO_ADDR_W:0] o_Fifo_Count,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  localparam int                     DEPTH    = 1 << FIFO_ADDR_W;
  localparam logic [15:0]            BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_ADDR_W:0]   CNT_FULL = (FIFO_ADDR_W + 1)'(DEPTH);
  localparam logic [FIFO_ADDR_W:0]   CNT_ONE  = (FIFO_ADDR_W + 1)'(1);
  localparam logic [FIFO_ADDR_W-1:0] PTR_ONE  = FIFO_ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]             mem_q [DEPTH];
  logic [FIFO_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR_W:0]   count_q, count_d;
  logic                   push;
  logic                   pop;
  logic                   fifo_empty;

  // Line FSM state
  state_t                 state_q;
  logic [15:0]            clk_cnt_q;
  logic [2:0]             bit_idx_q;
  logic [7:0]             shift_q;
  logic                   serial_q;
  logic                   active_q;
  logic                   done_q;
  logic                   bit_end;

  // Ready looks only at the stored count, so a same-cycle pop never opens a full FIFO
  assign o_Tx_Ready   = (count_q < CNT_FULL);
  assign fifo_empty   = (count_q == '0);
  assign push         = i_Tx_DV && o_Tx_Ready;
  assign bit_end      = (clk_cnt_q == BIT_LAST);

  assign o_Fifo_Count = count_q;
  assign o_Tx_Active  = active_q;
  assign o_Tx_Serial  = serial_q;
  assign o_Tx_Done    = done_q;

  // Pop the head when idle, or at the very end of a stop bit so frames stay contiguous
  always_comb begin
    pop = 1'b0;
    case (state_q)
      S_IDLE:  pop = !fifo_empty;
      S_STOP:  pop = bit_end && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  // Next FIFO pointers and occupancy; pointers wrap naturally modulo the depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and count registers; reset flushes the queue
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO data array; contents need no reset because count gates every read
  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_Tx_Byte;
    end
  end

  // Line FSM: start, eight data bits LSB first, stop; all line outputs registered
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          serial_q  <= 1'b1;
          active_q  <= 1'b0;
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          if (pop) begin
            shift_q  <= mem_q[rd_ptr_q];
            serial_q <= 1'b0;
            active_q <= 1'b1;
            state_q  <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            serial_q  <= shift_q[0];
            state_q   <= S_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              serial_q <= 1'b1;
              state_q  <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              serial_q  <= shift_q[bit_idx_q + 3'd1];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            done_q    <= 1'b1;
            if (pop) begin
              shift_q  <= mem_q[rd_ptr_q];
              serial_q <= 1'b0;
              state_q  <= S_START;
            end else begin
              active_q <= 1'b0;
              state_q  <= S_IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end

        default: begin
          serial_q  <= 1'b1;
          active_q  <= 1'b0;
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a timing model and a line decoder
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dv = 1'b0;
  logic [7:0]    tx_byte = 8'h00;
  logic          ready;
  logic [AW:0]   fcount;
  logic          active;
  logic          serial;
  logic          done;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_ADDR_W(AW)) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Tx_DV      (dv),
    .i_Tx_Byte    (tx_byte),
    .o_Tx_Ready   (ready),
    .o_Fifo_Count (fcount),
    .o_Tx_Active  (active),
    .o_Tx_Serial  (serial),
    .o_Tx_Done    (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: queued bytes, byte on the line and time elapsed in its frame
  logic [7:0] m_q[$];
  logic [7:0] m_cur = 8'h00;
  bit         m_busy = 1'b0;
  int         m_el = 0;
  bit         m_done = 1'b0;
  logic [7:0] exp_rx[$];
  logic [7:0] rx_q[$];
  int         done_cyc[$];

  typedef struct {
    logic [7:0] b;
    logic [9:0] frame;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic line_bit(input logic [7:0] b, input int el);
    int pos;
    pos = el / CPB;
    if (pos == 0) return 1'b0;
    if (pos >= 9) return 1'b1;
    return b[pos-1];
  endfunction

  task automatic model_step(input logic dv_v, input logic [7:0] b_v);
    int pre;
    pre    = m_q.size();
    m_done = 1'b0;
    if (m_busy) begin
      m_el++;
      if (m_el == FRAME) begin
        m_done = 1'b1;
        m_busy = 1'b0;
        exp_rx.push_back(m_cur);
      end
    end
    if (!m_busy && pre > 0) begin
      m_cur  = m_q.pop_front();
      m_busy = 1'b1;
      m_el   = 0;
    end
    if (dv_v && pre < DEPTH) m_q.push_back(b_v);
  endtask

  task automatic check_outputs();
    chk("serial", serial, m_busy ? line_bit(m_cur, m_el) : 1'b1);
    chk("active", active, m_busy);
    chk("count", fcount, m_q.size());
    chk("ready", ready, m_q.size() < DEPTH);
    chk("done", done, m_done);
  endtask

  task automatic tick(input logic dv_v, input logic [7:0] b_v);
    dv      = dv_v;
    tx_byte = b_v;
    @(posedge clk);
    model_step(dv_v, b_v);
    cyc++;
    @(negedge clk);
    if (done === 1'b1) done_cyc.push_back(cyc);
    check_outputs();
    dv      = 1'b0;
    tx_byte = 8'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 1000 && (m_busy || m_q.size() != 0); i++) tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    chk("drain_idle", active, 1'b0);
    chk("drain_count", fcount, 0);
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_serial", serial, 1'b1);
    chk("rst_active", active, 1'b0);
    chk("rst_count", fcount, 0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    m_q.delete();
    m_busy = 1'b0;
    m_el   = 0;
    m_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Send one byte into an idle transmitter and compare the line against a literal frame
  task automatic send_check(input logic [7:0] b, input logic [9:0] frame);
    int start_cyc;
    tick(1'b1, b);
    chk("pre_start_high", serial, 1'b1);
    tick(1'b0, 8'h00);
    start_cyc = cyc;
    chk("frame_bit", serial, frame[0]);
    for (int k = 1; k < FRAME; k++) begin
      tick(1'b0, 8'h00);
      chk("frame_bit", serial, frame[k / CPB]);
      chk("no_early_done", done, 1'b0);
    end
    tick(1'b0, 8'h00);
    chk("done_pulse", done, 1'b1);
    chk("done_latency", cyc - start_cyc, FRAME);
    tick(1'b0, 8'h00);
    chk("done_one_cycle", done, 1'b0);
  endtask

  // Behavioural receiver sampling mid-bit, independent of the transmitter's internals
  int         rx_c = 0;
  bit         rx_busy = 1'b0;
  logic [7:0] rx_sh = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      rx_busy = 1'b0;
    end else if (!rx_busy) begin
      if (serial === 1'b0) begin
        rx_busy = 1'b1;
        rx_c    = 0;
      end
    end else begin
      rx_c++;
      if ((rx_c % CPB) == CPB / 2 && rx_c / CPB >= 1 && rx_c / CPB <= 8)
        rx_sh[rx_c / CPB - 1] = serial;
      if (rx_c == 9 * CPB + CPB / 2) begin
        chk("rx_stop_bit", serial, 1'b1);
        rx_q.push_back(rx_sh);
        rx_busy = 1'b0;
      end
    end
  end

  initial begin
    int nd0;
    int rx0;
    int nff;

    vecs[0] = '{b: 8'h3C, frame: 10'b1_0011_1100_0};
    vecs[1] = '{b: 8'hA5, frame: 10'b1_1010_0101_0};
    vecs[2] = '{b: 8'h00, frame: 10'b1_0000_0000_0};
    vecs[3] = '{b: 8'hFF, frame: 10'b1_1111_1111_0};
    vecs[4] = '{b: 8'h81, frame: 10'b1_1000_0001_0};

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: line high, FIFO empty, no Done
    for (int i = 0; i < 20; i++) tick(1'b0, 8'h00);
    chk("idle_serial", serial, 1'b1);
    chk("idle_ready", ready, 1'b1);
    chk("idle_count", fcount, 0);
    chk("idle_done_count", done_cyc.size(), 0);

    // Reset in the middle of a 0x00 frame while the line is low
    tick(1'b1, 8'h00);
    for (int i = 0; i < 100 && !(m_busy && m_el == 4 * CPB + 1); i++) tick(1'b0, 8'h00);
    chk("t5_line_low", serial, 1'b0);
    nd0 = done_cyc.size();
    async_reset();
    for (int i = 0; i < 5; i++) tick(1'b0, 8'h00);
    chk("t5_no_done", done_cyc.size(), nd0);

    // Table of single frames, starting with 0x3C right after the reset
    foreach (vecs[i]) send_check(vecs[i].b, vecs[i].frame);

    // Five back-to-back writes fill the FIFO; 0xFF while full is dropped
    nd0 = done_cyc.size();
    rx0 = rx_q.size();
    for (int i = 1; i <= 5; i++) tick(1'b1, 8'(i));
    chk("t3_count_full", fcount, 4);
    chk("t3_ready_low", ready, 1'b0);
    tick(1'b1, 8'hFF);
    chk("t4_count_stays", fcount, 4);
    drain();
    chk("t3_done_pulses", done_cyc.size() - nd0, 5);
    for (int i = nd0 + 1; i < done_cyc.size() && i < nd0 + 5; i++)
      chk("t3_done_spacing", done_cyc[i] - done_cyc[i-1], FRAME);
    chk("t3_rx_count", rx_q.size() - rx0, 5);
    for (int i = 0; i < 5 && rx0 + i < rx_q.size(); i++)
      chk("t3_rx_order", rx_q[rx0 + i], i + 1);
    nff = 0;
    for (int i = rx0; i < rx_q.size(); i++) if (rx_q[i] == 8'hFF) nff++;
    chk("t4_ff_absent", nff, 0);

    // Write on the same edge the FSM pops at end of a stop bit
    rx0 = rx_q.size();
    tick(1'b1, 8'h11);
    tick(1'b1, 8'h22);
    tick(1'b1, 8'h33);
    for (int i = 0; i < 100 && !(m_busy && m_el == FRAME - 1); i++) tick(1'b0, 8'h00);
    chk("t6_count_before", fcount, 2);
    tick(1'b1, 8'h44);
    chk("t6_count_after", fcount, 2);
    drain();
    chk("t6_rx_count", rx_q.size() - rx0, 4);
    for (int i = 0; i < 4 && rx0 + i < rx_q.size(); i++)
      chk("t6_rx_order", rx_q[rx0 + i], 8'h11 * (i + 1));

    // Random traffic, with one asynchronous reset partway through
    for (int i = 0; i < 1200; i++) begin
      if (i == 600) async_reset();
      tick(($urandom_range(0, 7) == 0), 8'($urandom));
    end
    drain();

    // Everything the model saw complete must have been decoded, in order
    chk("rx_total", rx_q.size(), exp_rx.size());
    for (int i = 0; i < rx_q.size() && i < exp_rx.size(); i++)
      chk("rx_byte", rx_q[i], exp_rx[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
